de_stage_sequencer: RTL
=======================

// Module: de_stage_sequencer
// PURPOSE
//  Sequences the decode->execute pipeline register: holds fetch/decode, injects bubbles, flushes wrong-path work.
//  Expands CALL (2 cycles), RET (2 cycles) and INT (3 cycles) into per-cycle micro-steps via seq_phase.
//  The 32-bit PC moves through the 16-bit stack as two halves, one half per cycle.
//  Sits between the decoder/control unit and the D/E buffer; the E stage feeds its hazard inputs back.
// PARAMETERS
//  REG_AW    3  register-file address width (8 GPRs)
//  CALL_LEN  2  micro-steps for CALL (push PC hi, push PC lo)
//  RET_LEN   2  micro-steps for RET (pop PC lo, pop PC hi)
//  INT_LEN   3  micro-steps for INT (push PC hi, push PC lo, load vector)
// PORTS
//  clk              in   1       rising-edge clock
//  rst              in   1       synchronous, active-high reset
//  dec_valid        in   1       D stage holds a real instruction
//  dec_src1/2       in   REG_AW  D-stage source register addresses
//  dec_use1/2       in   1       D-stage instruction reads src1 / src2
//  dec_call/ret     in   1       D-stage instruction is CALL / RET
//  int_req          in   1       external interrupt, level; sampled each cycle
//  ex_mr            in   1       E-stage instruction is a memory read
//  ex_rw            in   1       E-stage instruction writes a register
//  ex_dest          in   REG_AW  E-stage destination register
//  ex_br_taken      in   1       E-stage branch/redirect resolved taken
//  stall_fd         out  1       hold PC and F/D buffer this cycle
//  bubble_de        out  1       load all-zero control into D/E buffer (NOP)
//  flush_fd         out  1       invalidate F/D buffer contents
//  seq_kind         out  2       0 none, 1 CALL, 2 RET, 3 INT; drives firstTimeCall/RET/INT select
//  seq_phase        out  2       0 idle, else current micro-step 1..LEN
//  int_ack          out  1       one-cycle pulse on INT entry
// BEHAVIOUR
//  - Registered state: st {RUN, SEQ}, kind, phase, int_pend. stall_fd/bubble_de/flush_fd are combinational from state and inputs (0-cycle latency).
//  - Reset (rst=1 at clk edge): st=RUN, kind=0, phase=0, int_pend=0, int_ack=0.
//  - While rst is high: bubble_de=1, flush_fd=1, stall_fd=0.
//  - Priority, highest first: rst > ex_br_taken > load-use > sequence start/advance.
//  - ex_br_taken=1: flush_fd=1, bubble_de=1, stall_fd=0.
//    - If in SEQ, abort immediately: next st=RUN, phase=0, kind=0 (wrong-path CALL/RET is discarded).
//    - int_pend is kept.
//  - Load-use, in RUN:
//    - Condition: ex_mr & ex_rw & dec_valid & ((dec_use1 & src1==ex_dest) | (dec_use2 & src2==ex_dest)).
//    - Response: stall_fd=1, bubble_de=1 for exactly one cycle. No forwarding wait beyond one cycle.
//  - int_pend:
//    - Set when int_req=1 in any cycle.
//    - Cleared on INT entry.
//    - A request arriving during SEQ waits for return to RUN.
//  - RUN->SEQ, evaluated only when no flush and no load-use this cycle. Precedence: int_pend > dec_call > dec_ret.
//    - int_pend & dec_valid: kind=INT, phase=1, int_ack pulses next cycle. The D instruction stays held and re-issues after the ISR.
//    - dec_call & dec_valid: kind=CALL, phase=1.
//    - dec_ret & dec_valid: kind=RET, phase=1.
//  - In SEQ: stall_fd=1, bubble_de=0; the D/E buffer captures the held instruction each cycle with the current seq_phase.
//    - phase increments each cycle.
//    - At phase==LEN(kind): next st=RUN, phase=0, kind=0.
//  - On the cycle SEQ returns to RUN:
//    - RET and INT: flush_fd=1 (PC redirected by E-stage micro-step; ex_br_taken asserts from E).
//    - CALL: the redirect also comes via ex_br_taken.
//  - Load-use is not evaluated during SEQ; E stage holds only sequence micro-ops then.
//  - Phase counter never wraps; values above LEN(kind) are unreachable (assert in sim).
// STRUCTURE
//  - Shared package mznm_pipe_pkg holds:
//    - state enum {RUN, SEQ}
//    - SEQ_NONE/CALL/RET/INT codes
//    - CALL_LEN/RET_LEN/INT_LEN
//    - NOP control-word constant
//  - Sub-module de_load_use_detect: purely combinational comparator, inputs dec_*/ex_*, output hazard.
// TESTING
//  1. Reset: rst high 2 cycles, then low.
//     -> During rst: bubble_de=1, flush_fd=1.
//     -> After: seq_kind=0, seq_phase=0, int_ack=0, stall_fd=0.
//  2. Load-use: ex_mr=1, ex_rw=1, ex_dest=3, dec_src1=3, dec_use1=1.
//     -> Exactly one cycle of stall_fd=1 and bubble_de=1, then 0.
//     -> Same stimulus with dec_use1=0 -> no stall.
//  3. CALL: dec_call=1, dec_valid=1.
//     -> seq_kind=1 with seq_phase 1,2 on consecutive cycles.
//     -> stall_fd=1 both cycles, bubble_de=0, then RUN.
//  4. INT during RET: int_req pulses at RET phase 1.
//     -> RET completes phases 1,2 with RET's return-to-RUN flush.
//     -> INT entry next: int_ack one pulse, seq_kind=3, phases 1,2,3, then flush_fd=1.
//  5. Branch abort: ex_br_taken=1 while in CALL phase 1.
//     -> Same cycle: flush_fd=1, bubble_de=1.
//     -> Next cycle: seq_phase=0, seq_kind=0.
//  6. Simultaneous: ex_br_taken=1 and load-use hazard in the same cycle.
//     -> flush wins: stall_fd=0, flush_fd=1, bubble_de=1.

Source files
------------

// File: rtl/mznm_pipe_pkg.sv
// Shared constants and types for the decode->execute sequencing logic.
package mznm_pipe_pkg;

  typedef enum logic [0:0] {
    ST_RUN = 1'b0,
    ST_SEQ = 1'b1
  } seq_st_e;

  localparam logic [1:0] SEQ_NONE = 2'd0;
  localparam logic [1:0] SEQ_CALL = 2'd1;
  localparam logic [1:0] SEQ_RET  = 2'd2;
  localparam logic [1:0] SEQ_INT  = 2'd3;

  localparam logic [1:0] CALL_LEN = 2'd2;  // push PC hi, push PC lo
  localparam logic [1:0] RET_LEN  = 2'd2;  // pop PC lo, pop PC hi
  localparam logic [1:0] INT_LEN  = 2'd3;  // push PC hi, push PC lo, load vector

  // All-zero control word loaded into the D/E buffer for a bubble.
  localparam logic [15:0] NOP_CTRL = 16'h0000;

  // Number of micro-steps for a sequence kind; 0 for SEQ_NONE.
  function automatic logic [1:0] seq_len(input logic [1:0] kind);
    logic [1:0] len;
    case (kind)
      SEQ_CALL: len = CALL_LEN;
      SEQ_RET:  len = RET_LEN;
      SEQ_INT:  len = INT_LEN;
      default:  len = 2'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/de_load_use_detect.sv
// Load-use hazard comparator: a D-stage read of a register that the
// E-stage memory read has not produced yet.
module de_load_use_detect #(
  parameter int REG_AW = 3
) (
  input  logic              dec_valid,
  input  logic [REG_AW-1:0] dec_src1,
  input  logic [REG_AW-1:0] dec_src2,
  input  logic              dec_use1,
  input  logic              dec_use2,
  input  logic              ex_mr,
  input  logic              ex_rw,
  input  logic [REG_AW-1:0] ex_dest,
  output logic              hazard
);

  // Either used source matches the pending load destination.
  always_comb begin
    hazard = ex_mr & ex_rw & dec_valid &
             ((dec_use1 & (dec_src1 == ex_dest)) |
              (dec_use2 & (dec_src2 == ex_dest)));
  end

endmodule

// File: rtl/de_stage_sequencer.sv
// Decode->execute pipeline register sequencer: stalls, bubbles, flushes and
// expands CALL / RET / INT into per-cycle micro-steps.
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | normal issue; load-use and sequence start are evaluated
// SEQ   | issuing micro-steps of kind, phase 1..seq_len(kind); D held
module de_stage_sequencer
  import mznm_pipe_pkg::*;
#(
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  input  logic [REG_AW-1:0] dec_src1,
  input  logic [REG_AW-1:0] dec_src2,
  input  logic              dec_use1,
  input  logic              dec_use2,
  input  logic              dec_call,
  input  logic              dec_ret,
  input  logic              int_req,
  input  logic              ex_mr,
  input  logic              ex_rw,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              ex_br_taken,
  output logic              stall_fd,
  output logic              bubble_de,
  output logic              flush_fd,
  output logic [1:0]        seq_kind,
  output logic [1:0]        seq_phase,
  output logic              int_ack
);

  seq_st_e    st_q, st_d;
  logic [1:0] kind_q, kind_d;
  logic [1:0] phase_q, phase_d;
  logic       int_pend_q, int_pend_d;
  logic       int_ack_d;
  // Set for the cycle after a load-use stall so the same hazard cannot
  // stall twice; the load has completed by then.
  logic       lu_stalled_q;

  logic       hazard;
  logic       lu_fire;
  logic       seq_start;
  logic       int_entry;
  logic       last_step;

  de_load_use_detect #(.REG_AW(REG_AW)) u_load_use (
    .dec_valid (dec_valid),
    .dec_src1  (dec_src1),
    .dec_src2  (dec_src2),
    .dec_use1  (dec_use1),
    .dec_use2  (dec_use2),
    .ex_mr     (ex_mr),
    .ex_rw     (ex_rw),
    .ex_dest   (ex_dest),
    .hazard    (hazard)
  );

  // Qualify hazard and sequence-start conditions against higher priorities.
  always_comb begin
    last_step = (st_q == ST_SEQ) && (phase_q == seq_len(kind_q));
    lu_fire   = (st_q == ST_RUN) && !ex_br_taken && hazard && !lu_stalled_q;
    seq_start = (st_q == ST_RUN) && !ex_br_taken && !lu_fire && dec_valid &&
                (int_pend_q || dec_call || dec_ret);
    int_entry = seq_start && int_pend_q;
  end

  // Pipeline control outputs. The start cycle also holds and bubbles so the
  // CALL/RET (or the instruction interrupted by INT) stays in D and is only
  // issued as micro-steps.
  always_comb begin
    stall_fd  = 1'b0;
    bubble_de = 1'b0;
    flush_fd  = 1'b0;
    if (rst) begin
      bubble_de = 1'b1;
      flush_fd  = 1'b1;
    end else if (ex_br_taken) begin
      bubble_de = 1'b1;
      flush_fd  = 1'b1;
    end else if (st_q == ST_SEQ) begin
      stall_fd = 1'b1;
      flush_fd = last_step && ((kind_q == SEQ_RET) || (kind_q == SEQ_INT));
    end else if (lu_fire || seq_start) begin
      stall_fd  = 1'b1;
      bubble_de = 1'b1;
    end
  end

  // Next-state: branch abort, micro-step advance, or sequence start.
  always_comb begin
    st_d       = st_q;
    kind_d     = kind_q;
    phase_d    = phase_q;
    int_pend_d = int_req | (int_pend_q & ~int_entry);
    int_ack_d  = int_entry;
    if (ex_br_taken) begin
      st_d    = ST_RUN;
      kind_d  = SEQ_NONE;
      phase_d = 2'd0;
    end else if (st_q == ST_SEQ) begin
      if (last_step) begin
        st_d    = ST_RUN;
        kind_d  = SEQ_NONE;
        phase_d = 2'd0;
      end else begin
        phase_d = phase_q + 2'd1;
      end
    end else if (seq_start) begin
      st_d    = ST_SEQ;
      phase_d = 2'd1;
      if (int_pend_q)    kind_d = SEQ_INT;
      else if (dec_call) kind_d = SEQ_CALL;
      else               kind_d = SEQ_RET;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q         <= ST_RUN;
      kind_q       <= SEQ_NONE;
      phase_q      <= 2'd0;
      int_pend_q   <= 1'b0;
      int_ack      <= 1'b0;
      lu_stalled_q <= 1'b0;
    end else begin
      st_q         <= st_d;
      kind_q       <= kind_d;
      phase_q      <= phase_d;
      int_pend_q   <= int_pend_d;
      int_ack      <= int_ack_d;
      lu_stalled_q <= lu_fire;
    end
  end

  assign seq_kind  = kind_q;
  assign seq_phase = phase_q;

  // The phase counter stays within the active sequence length and is idle in RUN.
  a_phase_range : assert property (@(posedge clk) disable iff (rst)
    (st_q == ST_SEQ) ? (phase_q >= 2'd1 && phase_q <= seq_len(kind_q))
                     : (phase_q == 2'd0 && kind_q == SEQ_NONE));

endmodule
